regfile_wr_arbiter: RTL and testbench

// Shares the single register-file write port between NREQ producers (crypto units,

---
 rtl/regfile_wr_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ producers,
// with a registered write stage and a 32-entry busy scoreboard.
module regfile_wr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*5-1:0]  req_addr,
   input  logic [NREQ*32-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic               rsv_valid,
   input  logic [4:0]         rsv_addr,
   output logic               rsv_ready,
   input  logic [4:0]         q0_addr,
   input  logic [4:0]         q1_addr,
   output logic               q0_busy,
   output logic               q1_busy,
   output logic [31:0]        busy,
   output logic               write_enable,
   output logic [4:0]         write_addr,
   output logic [31:0]        write_data
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] rr_q, rr_d;
   logic [31:0]   busy_q, busy_d;
   logic          we_q, we_d;
   logic [4:0]    wa_q, wa_d;
   logic [31:0]   wd_q, wd_d;

   logic [4:0]    a_arr [NREQ];
   logic [31:0]   d_arr [NREQ];
   logic          gnt;
   logic [PW-1:0] win;
   logic [PW-1:0] ix;
   logic [4:0]    g_addr;
   logic [31:0]   g_data;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = req_addr[i*5 +: 5];
         d_arr[i] = req_data[i*32 +: 32];
      end
   end

   // Search begins one past the last winner; first valid requester wins.
   always_comb begin
      req_ready = '0;
      gnt       = 1'b0;
      win       = rr_q;
      ix        = '0;
      g_addr    = '0;
      g_data    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         ix = PW'((int'(rr_q) + k) % NREQ);
         if (!gnt && req_valid[ix]) begin
            gnt           = 1'b1;
            win           = ix;
            req_ready[ix] = 1'b1;
            g_addr        = a_arr[ix];
            g_data        = d_arr[ix];
         end
      end
   end

   assign rsv_ready = ~busy_q[rsv_addr];
   assign q0_busy   = busy_q[q0_addr];
   assign q1_busy   = busy_q[q1_addr];
   assign busy      = busy_q;

   // Grant clears first; an accepted reservation then sets, so r0 never sticks.
   always_comb begin
      busy_d = busy_q;
      if (gnt)
         busy_d[g_addr] = 1'b0;
      if (rsv_valid && rsv_ready)
         busy_d[rsv_addr] = 1'b1;
      busy_d[0] = 1'b0;
      rr_d = gnt ? win : rr_q;
      we_d = gnt && (g_addr != 5'd0);
      wa_d = gnt ? g_addr : wa_q;
      wd_d = gnt ? g_data : wd_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q   <= PW'(NREQ - 1);
         busy_q <= '0;
         we_q   <= 1'b0;
         wa_q   <= '0;
         wd_q   <= '0;
      end else begin
         rr_q   <= rr_d;
         busy_q <= busy_d;
         we_q   <= we_d;
         wa_q   <= wa_d;
         wd_q   <= wd_d;
      end
   end

   assign write_enable = we_q;
   assign write_addr   = wa_q;
   assign write_data   = wd_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed
// by randomized traffic checked against a behavioural model.
module tb_regfile_wr_arbiter;

   localparam int N = 4;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*5-1:0]  req_addr;
   logic [N*32-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            rsv_valid;
   logic [4:0]      rsv_addr;
   logic            rsv_ready;
   logic [4:0]      q0_addr;
   logic [4:0]      q1_addr;
   logic            q0_busy;
   logic            q1_busy;
   logic [31:0]     busy;
   logic            write_enable;
   logic [4:0]      write_addr;
   logic [31:0]     write_data;

   regfile_wr_arbiter #(.NREQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .rsv_ready(rsv_ready),
      .q0_addr(q0_addr), .q1_addr(q1_addr),
      .q0_busy(q0_busy), .q1_busy(q1_busy),
      .busy(busy),
      .write_enable(write_enable),
      .write_addr(write_addr),
      .write_data(write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   bit          mb [32];
   int          m_last;
   bit          e_we;
   logic [4:0]  e_wa;
   logic [31:0] e_wd;
   int          last_w;

   bit          pv [N];
   logic [4:0]  pa [N];
   logic [31:0] pd [N];

   function automatic int arb(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N])
            return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mb[i] = 1'b0;
      m_last = N - 1;
      e_we   = 1'b0;
      e_wa   = '0;
      e_wd   = '0;
      last_w = -1;
   endtask

   task automatic check_all();
      int w;
      logic [31:0] bv;
      #1;
      w = arb(req_valid, m_last);
      for (int i = 0; i < 32; i++) bv[i] = mb[i];
      chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
      chk("rsv_ready", 32'(rsv_ready), 32'(!mb[rsv_addr]));
      chk("q0_busy", 32'(q0_busy), 32'(mb[q0_addr]));
      chk("q1_busy", 32'(q1_busy), 32'(mb[q1_addr]));
      chk("busy", busy, bv);
      chk("write_enable", 32'(write_enable), 32'(e_we));
      if (e_we) begin
         chk("write_addr", 32'(write_addr), 32'(e_wa));
         chk("write_data", write_data, e_wd);
      end
   endtask

   task automatic tick();
      int w;
      bit r_ok;
      logic [4:0]  ga;
      logic [31:0] gd;
      check_all();
      w    = arb(req_valid, m_last);
      r_ok = !mb[rsv_addr];
      ga   = '0;
      gd   = '0;
      if (w >= 0) begin
         ga = req_addr[w*5 +: 5];
         gd = req_data[w*32 +: 32];
      end
      @(posedge clk);
      if (w >= 0) begin
         m_last = w;
         e_we   = (ga != 5'd0);
         e_wa   = ga;
         e_wd   = gd;
         mb[ga] = 1'b0;
      end else begin
         e_we = 1'b0;
      end
      if (rsv_valid && r_ok && rsv_addr != 5'd0)
         mb[rsv_addr] = 1'b1;
      last_w = w;
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      rsv_valid = 1'b0;
      rsv_addr  = '0;
      q0_addr   = '0;
      q1_addr   = '0;
      model_reset();
      @(negedge clk);
      check_all();
      rst = 1'b0;

      // Single request, plus a reservation so reset has busy state to clear
      req_valid        = 4'b0001;
      req_addr[4:0]    = 5'd5;
      req_data[31:0]   = 32'hDEADBEEF;
      rsv_valid        = 1'b1;
      rsv_addr         = 5'd3;
      #1 chk("single_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = '0;
      rsv_valid = 1'b0;
      #1;
      chk("single_we", 32'(write_enable), 32'd1);
      chk("single_addr", 32'(write_addr), 32'd5);
      chk("single_data", write_data, 32'hDEADBEEF);
      chk("single_busy3", 32'(busy[3]), 32'd1);

      // Reset while a write is in the output stage
      rst = 1'b1;
      #1;
      chk("rst_we", 32'(write_enable), 32'd0);
      chk("rst_busy", busy, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Fairness: all requesters valid continuously
      for (int i = 0; i < N; i++) begin
         req_addr[i*5 +: 5]   = 5'(10 + i);
         req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      end
      req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         #1 chk("fair_ready", 32'(req_ready), 32'd1 << (c % N));
         if (c > 0)
            chk("fair_we", 32'(write_enable), 32'd1);
         tick();
      end
      req_valid = '0;
      tick();

      // Write to r0: handshake completes, no regfile write
      req_valid         = 4'b0100;
      req_addr[14:10]   = 5'd0;
      req_data[95:64]   = 32'h1234_5678;
      #1 chk("r0_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      #1 chk("r0_we", 32'(write_enable), 32'd0);
      tick();

      // Scoreboard reserve / query / clear on grant
      rsv_valid = 1'b1;
      rsv_addr  = 5'd7;
      q0_addr   = 5'd7;
      #1 chk("rsv7_ready", 32'(rsv_ready), 32'd1);
      tick();
      #1;
      chk("busy7_set", 32'(busy[7]), 32'd1);
      chk("q0_busy7", 32'(q0_busy), 32'd1);
      chk("rsv7_again", 32'(rsv_ready), 32'd0);
      tick();
      rsv_valid     = 1'b0;
      req_valid     = 4'b0010;
      req_addr[9:5] = 5'd7;
      tick();
      req_valid = '0;
      #1;
      chk("busy7_clr", 32'(busy[7]), 32'd0);
      chk("q0_busy7_clr", 32'(q0_busy), 32'd0);

      // Collision: reservation and grant of r9 in the same cycle
      rsv_valid = 1'b1;
      rsv_addr  = 5'd9;
      tick();
      req_valid        = 4'b1000;
      req_addr[19:15]  = 5'd9;
      req_data[127:96] = 32'hCAFE_0009;
      #1 chk("coll_rsv_ready", 32'(rsv_ready), 32'd0);
      tick();
      req_valid = '0;
      #1;
      chk("coll_busy9", 32'(busy[9]), 32'd0);
      chk("retry_ready", 32'(rsv_ready), 32'd1);
      tick();
      rsv_valid = 1'b0;
      #1 chk("retry_busy9", 32'(busy[9]), 32'd1);
      tick();

      // Randomized traffic with requesters holding addr/data until granted
      for (int i = 0; i < N; i++) pv[i] = 1'b0;
      last_w = -1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (last_w == i)
               pv[i] = 1'b0;
            if (!pv[i] && $urandom_range(0, 2) == 0) begin
               pv[i] = 1'b1;
               pa[i] = 5'($urandom % 8);
               pd[i] = $urandom;
            end
            req_valid[i]         = pv[i];
            req_addr[i*5 +: 5]   = pa[i];
            req_data[i*32 +: 32] = pd[i];
         end
         rsv_valid = 1'($urandom % 2);
         rsv_addr  = 5'($urandom % 8);
         q0_addr   = 5'($urandom % 8);
         q1_addr   = 5'($urandom % 8);
         tick();
      end
      req_valid = '0;
      rsv_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
